shift_rows_pipe: RTL

Registered, parametrised Rijndael ShiftRows/InvShiftRows stage for the round datapath. It supports block widths of NB = 4, 6 or 8 columns, selects forward or inverse per transaction, and can pass a transaction through unpermuted. A two-entry output buffer with valid/ready handshakes sits on both sides, so the stage can be inserted between SubBytes and MixColumns without breaking any combinational ready path.

---
 rtl/shift_rows_pkg.sv | 27 ++
 rtl/shift_rows_perm.sv | 39 +++
 rtl/shift_rows_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_rows_pkg.sv
// Shared helpers for the ShiftRows stage: row offsets, byte placement, legal widths.
// No logic here; all functions are evaluated at elaboration time.
// No flow control of its own.
package shift_rows_pkg;

  // Only the three Rijndael block widths are meaningful for this stage.
  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // State width in bits for a given column count.
  function automatic int data_w(input int nb);
    return 32 * nb;
  endfunction

  // Rotation of row r: the wide 8-column block moves rows 2 and 3 one further.
  function automatic int row_shift(input int nb, input int r);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // LSB position of byte (r,c); byte index 8*(4c+r) counts down from the MSB.
  function automatic int byte_lsb(input int nb, input int r, input int c);
    return data_w(nb) - 8 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation with bypass.
// Zero latency; pure wiring plus one 3-way select.
// No flow control; the caller owns the handshake.
module shift_rows_perm
  import shift_rows_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_data,
  input  logic             inv,
  input  logic             bypass,
  output logic [32*NB-1:0] out_data
);

  localparam int W = data_w(NB);

  logic [W-1:0] fwd_dat;
  logic [W-1:0] inv_dat;

  // Each output byte picks its source column in the same row, rotated by the row offset.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int S   = row_shift(NB, r);
      localparam int DST = byte_lsb(NB, r, c);
      localparam int SF  = byte_lsb(NB, r, (c + S) % NB);
      localparam int SI  = byte_lsb(NB, r, (c + NB - S) % NB);
      assign fwd_dat[DST +: 8] = in_data[SF +: 8];
      assign inv_dat[DST +: 8] = in_data[SI +: 8];
    end
  end

  // Bypass wins over direction select.
  always_comb begin
    out_data = fwd_dat;
    if (bypass)   out_data = in_data;
    else if (inv) out_data = inv_dat;
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows/InvShiftRows stage with a 2-entry output FIFO.
// Latency 1 cycle from accept to out_valid; 1 transaction/cycle when out_ready high.
// in_ready comes from registered occupancy only, so no combinational ready path.
module shift_rows_pipe
  import shift_rows_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  input  logic             in_bypass,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int W = data_w(NB);

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("shift_rows_pipe: TAG_W must be at least 1");
  end

  logic [W-1:0]     perm_dat;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [W-1:0]     dat_q [2];
  logic [W-1:0]     dat_d [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [TAG_W-1:0] tag_d [2];
  logic             push;
  logic             pop;

  shift_rows_perm #(.NB(NB)) u_perm (
    .in_data  (in_data),
    .inv      (in_inv),
    .bypass   (in_bypass),
    .out_data (perm_dat)
  );

  // Ready is held low during reset so nothing is accepted into a buffer being cleared.
  assign in_ready  = !rst && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = dat_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for occupancy, pointers and storage; clear discards same-cycle push/pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dat_d    = dat_q;
    tag_d    = tag_q;
    if (clear) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        dat_d[wr_ptr_q] = perm_dat;
        tag_d[wr_ptr_q] = in_tag;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is zeroed so the head never shows X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      dat_q[0] <= '0;
      dat_q[1] <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dat_q    <= dat_d;
      tag_q    <= tag_d;
    end
  end

endmodule
